// File: rtl/fetch_sequencer_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and executor.
// The slave modport is the sequencer; master is whatever drives it.
interface fetch_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_start;
  logic                  i_mem_ready;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  i_exec_busy;
  logic                  i_jump_req;
  logic                  i_jump_cond;
  logic                  i_halt;
  logic                  o_reset_ip;
  logic                  o_hold_ip_flag;
  logic                  o_memory_address_source;
  logic                  o_select_jump_address;
  logic                  o_mem_req;
  logic [DATA_WIDTH-1:0] o_instr;
  logic                  o_instr_valid;
  logic [15:0]           o_fetch_count;
  logic                  o_error;
  logic [2:0]            o_state;

  modport slave (
    input  i_start, i_mem_ready, i_mem_data, i_exec_busy, i_jump_req, i_jump_cond, i_halt,
    output o_reset_ip, o_hold_ip_flag, o_memory_address_source, o_select_jump_address,
           o_mem_req, o_instr, o_instr_valid, o_fetch_count, o_error, o_state
  );

  modport master (
    output i_start, i_mem_ready, i_mem_data, i_exec_busy, i_jump_req, i_jump_cond, i_halt,
    input  o_reset_ip, o_hold_ip_flag, o_memory_address_source, o_select_jump_address,
           o_mem_req, o_instr, o_instr_valid, o_fetch_count, o_error, o_state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch control FSM: requests a word, waits (bounded) for memory,
// presents it to the executor and steers the instruction pointer on accept.
module fetch_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  fetch_sequencer_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_ISSUE = 3'd3,
    S_JUMP  = 3'd4,
    S_HALT  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [15:0]           fetch_count_q, fetch_count_d;
  logic                  error_q, error_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  jump_cond_q, jump_cond_d;

  logic reset_ip;
  logic hold_ip;
  logic addr_src;
  logic sel_jump;
  logic mem_req;
  logic instr_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      fetch_count_q <= '0;
      error_q       <= 1'b0;
      wait_cnt_q    <= '0;
      jump_cond_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      error_q       <= error_d;
      wait_cnt_q    <= wait_cnt_d;
      jump_cond_q   <= jump_cond_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    error_d       = error_q;
    wait_cnt_d    = wait_cnt_q;
    jump_cond_d   = jump_cond_q;
    reset_ip      = 1'b0;
    hold_ip       = 1'b0;
    addr_src      = 1'b0;
    sel_jump      = 1'b0;
    mem_req       = 1'b0;
    instr_valid   = 1'b0;

    case (state_q)
      S_IDLE: begin
        reset_ip = 1'b1;
        hold_ip  = 1'b1;
        if (bus.i_start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req    = 1'b1;
        hold_ip    = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        mem_req = 1'b1;
        hold_ip = 1'b1;
        // A ready arriving on the final allowed cycle beats the timeout.
        if (bus.i_mem_ready) begin
          instr_d       = bus.i_mem_data;
          fetch_count_d = fetch_count_q + 16'd1;
          state_d       = S_ISSUE;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          error_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        hold_ip     = 1'b1;
        if (!bus.i_exec_busy) begin
          jump_cond_d = bus.i_jump_cond;
          if (bus.i_halt) begin
            state_d = S_HALT;
          end else if (bus.i_jump_req) begin
            state_d = S_JUMP;
          end else begin
            // Sequential advance: release the IP for exactly this cycle.
            hold_ip = 1'b0;
            state_d = S_FETCH;
          end
        end
      end
      S_JUMP: begin
        addr_src = 1'b1;
        sel_jump = ~jump_cond_q;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        hold_ip = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.o_reset_ip              = reset_ip;
  assign bus.o_hold_ip_flag          = hold_ip;
  assign bus.o_memory_address_source = addr_src;
  assign bus.o_select_jump_address   = sel_jump;
  assign bus.o_mem_req               = mem_req;
  assign bus.o_instr_valid           = instr_valid;
  assign bus.o_instr                 = instr_q;
  assign bus.o_fetch_count           = fetch_count_q;
  assign bus.o_error                 = error_q;
  assign bus.o_state                 = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_fetch_sequencer;
  localparam int DW = 8;
  localparam int TO = 15;

  localparam int ST_IDLE  = 0;
  localparam int ST_FETCH = 1;
  localparam int ST_WAIT  = 2;
  localparam int ST_ISSUE = 3;
  localparam int ST_JUMP  = 4;
  localparam int ST_HALT  = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.DATA_WIDTH(DW)) bus();

  fetch_sequencer #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  int            m_st;
  logic [DW-1:0] m_instr;
  int            m_cnt;
  logic          m_err;
  int            m_wait;
  logic          m_jc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = ST_IDLE; m_instr = '0; m_cnt = 0; m_err = 1'b0; m_wait = 0; m_jc = 1'b0;
  endtask

  task automatic compare_outputs();
    logic accept, seq_adv;
    accept  = (m_st == ST_ISSUE) && !bus.i_exec_busy;
    seq_adv = accept && !bus.i_halt && !bus.i_jump_req;
    check("state",       32'(bus.o_state), 32'(m_st));
    check("reset_ip",    32'(bus.o_reset_ip), 32'(m_st == ST_IDLE));
    check("hold_ip",     32'(bus.o_hold_ip_flag),
          32'((m_st == ST_IDLE) || (m_st == ST_FETCH) || (m_st == ST_WAIT) ||
              (m_st == ST_HALT) || ((m_st == ST_ISSUE) && !seq_adv)));
    check("addr_src",    32'(bus.o_memory_address_source), 32'(m_st == ST_JUMP));
    check("sel_jump",    32'(bus.o_select_jump_address), 32'((m_st == ST_JUMP) && !m_jc));
    check("mem_req",     32'(bus.o_mem_req), 32'((m_st == ST_FETCH) || (m_st == ST_WAIT)));
    check("instr_valid", 32'(bus.o_instr_valid), 32'(m_st == ST_ISSUE));
    check("instr",       32'(bus.o_instr), 32'(m_instr));
    check("fetch_count", 32'(bus.o_fetch_count), 32'(m_cnt));
    check("error",       32'(bus.o_error), 32'(m_err));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else if (m_st == ST_IDLE) begin
      if (bus.i_start) m_st = ST_FETCH;
    end else if (m_st == ST_FETCH) begin
      m_wait = 0;
      m_st   = ST_WAIT;
    end else if (m_st == ST_WAIT) begin
      if (bus.i_mem_ready) begin
        m_instr = bus.i_mem_data;
        m_cnt   = (m_cnt + 1) % 65536;
        m_st    = ST_ISSUE;
      end else if (m_wait == TO) begin
        m_err = 1'b1;
        m_st  = ST_HALT;
      end else begin
        m_wait++;
      end
    end else if (m_st == ST_ISSUE) begin
      if (!bus.i_exec_busy) begin
        m_jc = bus.i_jump_cond;
        if (bus.i_halt)          m_st = ST_HALT;
        else if (bus.i_jump_req) m_st = ST_JUMP;
        else                     m_st = ST_FETCH;
      end
    end else if (m_st == ST_JUMP) begin
      m_st = ST_FETCH;
    end
  endtask

  // Inputs are set just after a falling edge; outputs are sampled 1ns later.
  task automatic step(input int want_state);
    #1;
    compare_outputs();
    if (want_state >= 0) check("state_seq", 32'(bus.o_state), 32'(want_state));
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_start = 1'b0; bus.i_mem_ready = 1'b0; bus.i_mem_data = '0;
    bus.i_exec_busy = 1'b0; bus.i_jump_req = 1'b0; bus.i_jump_cond = 1'b0; bus.i_halt = 1'b0;
  endtask

  initial begin
    logic drought;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    step(ST_IDLE);

    // Basic fetch: ready on the second WAIT cycle, sequential accept.
    rst_n = 1'b1; bus.i_start = 1'b1; step(ST_IDLE);
    bus.i_start = 1'b0; step(ST_FETCH);
    step(ST_WAIT);
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 8'h5A; step(ST_WAIT);
    bus.i_mem_ready = 1'b0; bus.i_mem_data = 8'h00;
    #1 check("issue_hold_released", 32'(bus.o_hold_ip_flag), 32'd0);
    step(ST_ISSUE);
    #1 check("instr_5a", 32'(bus.o_instr), 32'h5A);
    check("count_one", 32'(bus.o_fetch_count), 32'd1);
    step(ST_FETCH);

    // Executor busy for three cycles, then jump with cond=0.
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 8'hC3; step(ST_WAIT);
    bus.i_mem_ready = 1'b0; bus.i_exec_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("busy_valid", 32'(bus.o_instr_valid), 32'd1);
      check("busy_hold", 32'(bus.o_hold_ip_flag), 32'd1);
      step(ST_ISSUE);
    end
    bus.i_exec_busy = 1'b0; bus.i_jump_req = 1'b1; bus.i_jump_cond = 1'b0; step(ST_ISSUE);
    bus.i_jump_req = 1'b0;
    #1 check("jump_src", 32'(bus.o_memory_address_source), 32'd1);
    check("jump_sel_uncond", 32'(bus.o_select_jump_address), 32'd1);
    check("jump_hold", 32'(bus.o_hold_ip_flag), 32'd0);
    check("busy_no_extra_count", 32'(bus.o_fetch_count), 32'd2);
    step(ST_JUMP);
    step(ST_FETCH);

    // Conditional jump.
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 8'h11; step(ST_WAIT);
    bus.i_mem_ready = 1'b0; bus.i_jump_req = 1'b1; bus.i_jump_cond = 1'b1; step(ST_ISSUE);
    bus.i_jump_req = 1'b0; bus.i_jump_cond = 1'b0;
    #1 check("jump_sel_cond", 32'(bus.o_select_jump_address), 32'd0);
    step(ST_JUMP);
    step(ST_FETCH);

    // Timeout: sixteen WAIT cycles with no ready, then HALT with error.
    for (int i = 0; i < TO + 1; i++) step(ST_WAIT);
    #1 check("timeout_error", 32'(bus.o_error), 32'd1);
    step(ST_HALT);
    bus.i_mem_ready = 1'b1; step(ST_HALT);
    bus.i_mem_ready = 1'b0;
    check("halt_ignores_ready", 32'(bus.o_fetch_count), 32'd3);

    // Reset, then ready on the last permitted WAIT cycle wins.
    rst_n = 1'b0; step(ST_HALT);
    rst_n = 1'b1; bus.i_start = 1'b1; step(ST_IDLE);
    bus.i_start = 1'b0; step(ST_FETCH);
    for (int i = 0; i < TO; i++) step(ST_WAIT);
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 8'hA7; step(ST_WAIT);
    bus.i_mem_ready = 1'b0;
    #1 check("late_ready_no_error", 32'(bus.o_error), 32'd0);
    step(ST_ISSUE);
    step(ST_FETCH);

    // Reset in the middle of WAIT.
    step(ST_WAIT);
    rst_n = 1'b0; step(ST_WAIT);
    rst_n = 1'b1;
    #1 check("midwait_reset_count", 32'(bus.o_fetch_count), 32'd0);
    step(ST_IDLE);

    // Halt beats jump at acceptance; start is ignored afterwards.
    bus.i_start = 1'b1; step(ST_IDLE);
    bus.i_start = 1'b0; step(ST_FETCH);
    bus.i_mem_ready = 1'b1; bus.i_mem_data = 8'h3C; step(ST_WAIT);
    bus.i_mem_ready = 1'b0; bus.i_halt = 1'b1; bus.i_jump_req = 1'b1; step(ST_ISSUE);
    bus.i_halt = 1'b0; bus.i_jump_req = 1'b0; bus.i_start = 1'b1;
    step(ST_HALT);
    step(ST_HALT);
    bus.i_start = 1'b0;

    // Random traffic against the model.
    drought = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ((cyc % 150) == 0) drought = ($urandom_range(0, 3) == 0);
      rst_n            = ($urandom_range(0, 79) != 0);
      bus.i_start      = ($urandom_range(0, 3) == 0);
      bus.i_mem_ready  = drought ? 1'b0 : ($urandom_range(0, 2) == 0);
      bus.i_mem_data   = DW'($urandom);
      bus.i_exec_busy  = ($urandom_range(0, 1) == 0);
      bus.i_jump_req   = ($urandom_range(0, 2) == 0);
      bus.i_jump_cond  = 1'($urandom);
      bus.i_halt       = ($urandom_range(0, 15) == 0);
      step(-1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: instruction/data word width.
REQ-002 Parameter TIMEOUT, default 15: maximum idle WAIT cycles before error, 1..255.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_start  input  1  leave IDLE and begin fetching.
REQ-006 i_mem_ready  input  1  memory data valid this cycle.
REQ-007 i_mem_data  input  DATA_WIDTH  fetched instruction word.
REQ-008 i_exec_busy  input  1  executor cannot accept the presented instruction.
REQ-009 i_jump_req  input  1  presented instruction is a jump (sampled with acceptance).
REQ-010 i_jump_cond  input  1  jump is conditional (sampled with acceptance).
REQ-011 i_halt  input  1  presented instruction is HALT (sampled with acceptance).
REQ-012 o_reset_ip  output  1  forces address calculator output to 0.
REQ-013 o_hold_ip_flag  output  1  freezes instruction pointer.
REQ-014 o_memory_address_source  output  1  selects target address.
REQ-015 o_select_jump_address  output  1  unconditional jump select.
REQ-016 o_mem_req  output  1  memory read request.
REQ-017 o_instr  output  DATA_WIDTH  registered captured instruction.
REQ-018 o_instr_valid  output  1  o_instr presented to executor.
REQ-019 o_fetch_count  output  16  count of captured instructions.
REQ-020 o_error  output  1  sticky memory-timeout flag.
REQ-021 o_state  output  3  current FSM encoding.

Function
REQ-022 States SHALL be IDLE=0, FETCH=1, WAIT=2, ISSUE=3, JUMP=4, HALT=5; codes 6/7 SHALL go to IDLE next cycle.
REQ-023 IDLE: o_reset_ip=1, o_hold_ip_flag=1; i_start=1 -> FETCH; i_start in any other state SHALL be ignored.
REQ-024 FETCH: o_mem_req=1, hold=1; unconditionally -> WAIT, wait counter cleared to 0.
REQ-025 WAIT: o_mem_req=1, hold=1; i_mem_ready=1 -> capture i_mem_data into o_instr, increment o_fetch_count, -> ISSUE.
REQ-026 WAIT with i_mem_ready=0: counter increments; if counter==TIMEOUT -> HALT and o_error set; i_mem_ready=1 in that same cycle SHALL win (capture, no error), so the maximum wait is TIMEOUT+1 cycles.
REQ-027 i_mem_ready outside WAIT SHALL be ignored (no capture, no count).
REQ-028 ISSUE: o_instr_valid=1, hold=1 while i_exec_busy=1 (stay); acceptance = ISSUE and i_exec_busy=0.
REQ-029 On acceptance, priority i_halt > i_jump_req > sequential: halt -> HALT (hold stays 1); jump -> JUMP; otherwise o_hold_ip_flag=0 in that cycle and -> FETCH.
REQ-030 JUMP (one cycle): hold=0, o_memory_address_source=1, o_select_jump_address = NOT registered i_jump_cond captured at acceptance; -> FETCH.
REQ-031 HALT: hold=1, all other control outputs 0; exits only by reset.
REQ-032 o_reset_ip, o_hold_ip_flag, o_memory_address_source, o_select_jump_address, o_mem_req, o_instr_valid SHALL be combinational from state (plus i_exec_busy/i_halt/i_jump_req in ISSUE only); o_instr, o_fetch_count, o_error registered.
REQ-033 o_fetch_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-034 Outputs not named per state SHALL be 0 in that state.

Reset
REQ-035 rst_n=0 at an edge SHALL, from any state, set state IDLE, o_instr=0, o_fetch_count=0, o_error=0, wait counter=0, captured jump_cond=0.
REQ-036 During/after reset, outputs SHALL be o_reset_ip=1, o_hold_ip_flag=1, all others 0, o_state=0.

Verification
REQ-037 Reset, i_start pulse, ready 2 cycles after FETCH with data 0x5A, busy=0 -> states 0,1,2,2,3,1; o_instr=0x5A; hold=0 exactly in ISSUE cycle; count=1.
REQ-038 ISSUE with i_exec_busy=1 for 3 cycles -> o_instr_valid=1 and hold=1 for 3 cycles, then acceptance; no extra count.
REQ-039 Accept with i_jump_req=1, i_jump_cond=0 -> JUMP cycle with source=1, select=1, hold=0; with i_jump_cond=1 -> select=0.
REQ-040 No ready, TIMEOUT=15 -> 16 WAIT cycles then HALT, o_error=1; repeat with ready on 16th cycle -> ISSUE, o_error=0.
REQ-041 i_halt=1 and i_jump_req=1 at acceptance -> HALT; later i_start ignored; rst_n=0 mid-WAIT -> IDLE, count=0 next cycle.
